// File: rtl/eq_delay_line_ctrl_pkg.sv
// rtl/eq_delay_line_ctrl_pkg.sv - shared state encoding and default sizes for the delay-line sequencer
package eq_delay_line_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_WRITE = 3'd2,
      ST_READ  = 3'd3,
      ST_FLUSH = 3'd4
   } state_t;

   localparam int DefAddrWidth = 9;
   localparam int DefDataWidth = 16;
   localparam int DefNumTaps   = 32;
   localparam int DefTapWidth  = 5;

endpackage

// File: rtl/eq_delay_line_ctrl.sv
// rtl/eq_delay_line_ctrl.sv - circular delay-line sequencer: zero-fill, write sample, stream NumTaps taps newest first
module eq_delay_line_ctrl
   import eq_delay_line_ctrl_pkg::*;
#(
   parameter int AddrWidth = DefAddrWidth,
   parameter int DataWidth = DefDataWidth,
   parameter int MaxAddr   = 2**DefAddrWidth - 1,
   parameter int NumTaps   = DefNumTaps,
   parameter int TapWidth  = DefTapWidth
) (
   input  logic                 Clk,
   input  logic                 Rst_n,
   input  logic                 SampleValid,
   input  logic [DataWidth-1:0] SampleIn,
   output logic                 SampleReady,
   output logic                 TapValid,
   input  logic                 TapReady,
   output logic [DataWidth-1:0] TapData,
   output logic [TapWidth-1:0]  TapIndex,
   output logic                 TapLast,
   output logic                 RamWr,
   output logic [AddrWidth-1:0] RamAddr,
   output logic [DataWidth-1:0] RamDin,
   input  logic [DataWidth-1:0] RamDout,
   output logic                 Busy
);

   state_t               state;
   logic [AddrWidth-1:0] wr_ptr;
   logic [AddrWidth-1:0] rd_ptr;
   logic [AddrWidth-1:0] clr_cnt;
   logic [TapWidth-1:0]  tap_cnt;
   logic [DataWidth-1:0] samp_q;
   logic                 load;
   logic                 tap_is_last;

   assign load        = !TapValid || TapReady;
   assign tap_is_last = (tap_cnt == TapWidth'(NumTaps - 1));

   // RAM read is asynchronous, so the address must follow the pointers combinationally;
   // the write strobe is held off while reset is asserted.
   always_comb begin
      SampleReady = (state == ST_IDLE);
      Busy        = (state != ST_IDLE);
      RamWr       = Rst_n && ((state == ST_CLEAR) || (state == ST_WRITE));
      RamDin      = '0;
      RamAddr     = rd_ptr;
      case (state)
         ST_CLEAR: RamAddr = clr_cnt;
         ST_WRITE: begin
            RamAddr = wr_ptr;
            RamDin  = samp_q;
         end
         default:  RamAddr = rd_ptr;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state    <= ST_CLEAR;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         clr_cnt  <= '0;
         tap_cnt  <= '0;
         samp_q   <= '0;
         TapValid <= 1'b0;
         TapData  <= '0;
         TapIndex <= '0;
         TapLast  <= 1'b0;
      end else begin
         case (state)
            ST_CLEAR: begin
               clr_cnt <= clr_cnt + 1'b1;
               if (clr_cnt == AddrWidth'(MaxAddr))
                  state <= ST_IDLE;
            end
            ST_IDLE: begin
               if (SampleValid) begin
                  samp_q <= SampleIn;
                  state  <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               rd_ptr  <= wr_ptr;
               tap_cnt <= '0;
               state   <= ST_READ;
            end
            ST_READ: begin
               // Output register reloads whenever it is empty or being drained.
               if (load) begin
                  TapData  <= RamDout;
                  TapIndex <= tap_cnt;
                  TapLast  <= tap_is_last;
                  TapValid <= 1'b1;
                  rd_ptr   <= rd_ptr - 1'b1;
                  tap_cnt  <= tap_cnt + 1'b1;
                  if (tap_is_last)
                     state <= ST_FLUSH;
               end
            end
            ST_FLUSH: begin
               if (TapValid && TapReady) begin
                  TapValid <= 1'b0;
                  TapLast  <= 1'b0;
                  wr_ptr   <= wr_ptr + 1'b1;
                  state    <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
